// File: rtl/seven_seg_scan_ctrl.sv
// Multiplexed N-digit 7-segment controller: binary load over valid/ready, sequential
// double-dabble BCD conversion, atomic commit, and a registered digit scan.
module seven_seg_scan_ctrl #(
  parameter int NUM_DIGITS  = 4,
  parameter int DATA_W      = 16,
  parameter int REFRESH_DIV = 262144,
  parameter int ACTIVE_LOW  = 1,
  parameter int BLANK_LZ    = 1
) (
  input  logic                  clock_100Mhz,
  input  logic                  reset,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [DATA_W-1:0]     load_value,
  input  logic [NUM_DIGITS-1:0] dp_mask,
  output logic                  busy,
  output logic                  overflow,
  output logic [NUM_DIGITS-1:0] Anode_Activate,
  output logic [6:0]            LED_out,
  output logic                  DP_out
);

  localparam int BCD_FROM_DATA = (DATA_W + 2) / 3;
  localparam int SCR_DIGITS    = (NUM_DIGITS > BCD_FROM_DATA) ? NUM_DIGITS : BCD_FROM_DATA;
  localparam int SCR_W         = 4 * SCR_DIGITS;
  localparam int DISP_W        = 4 * NUM_DIGITS;
  localparam int CNT_W         = $clog2(DATA_W);
  localparam int REF_W         = $clog2(REFRESH_DIV);
  localparam int IDX_W         = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [NUM_DIGITS-1:0] ANODE_OFF = (ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};
  localparam logic [6:0]            LED_OFF   = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic                  DP_OFF    = (ACTIVE_LOW != 0);

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

  state_t                  state_q, state_d;
  logic [DATA_W-1:0]       value_q, value_d;
  logic [SCR_W-1:0]        scratch_q, scratch_d;
  logic [SCR_W-1:0]        adjusted;
  logic [CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DISP_W-1:0]       disp_q, disp_d;
  logic                    overflow_q, overflow_d;
  logic                    hi_nonzero;
  logic [REF_W-1:0]        refresh_q, refresh_d;
  logic [IDX_W-1:0]        index_q, index_d;
  logic [NUM_DIGITS-1:0]   anode_q, anode_d;
  logic [6:0]              led_q, led_d;
  logic                    dp_q, dp_d;
  logic [DISP_W-1:0]       upper_digits;
  logic [NUM_DIGITS-1:0]   anode_hi;
  logic [6:0]              seg_hi;

  // Add 3 to every nibble >= 5 so the following left shift carries correctly into BCD.
  function automatic logic [SCR_W-1:0] dabble(input logic [SCR_W-1:0] s);
    logic [SCR_W-1:0] r;
    r = s;
    for (int i = 0; i < SCR_DIGITS; i++) begin
      if (s[4*i +: 4] >= 4'd5) r[4*i +: 4] = s[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  assign adjusted = dabble(scratch_q);

  if (SCR_W > DISP_W) begin : g_hi
    assign hi_nonzero = |scratch_q[SCR_W-1:DISP_W];
  end else begin : g_no_hi
    assign hi_nonzero = 1'b0;
  end

  always_ff @(posedge clock_100Mhz or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (load_valid) state_d = SHIFT;
      SHIFT:   if (bit_cnt_q == CNT_W'(DATA_W - 1)) state_d = COMMIT;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    load_ready = (state_q == IDLE);
    busy       = (state_q == SHIFT) || (state_q == COMMIT);
  end

  always_comb begin
    value_d    = value_q;
    scratch_d  = scratch_q;
    bit_cnt_d  = bit_cnt_q;
    disp_d     = disp_q;
    overflow_d = overflow_q;
    case (state_q)
      IDLE: begin
        if (load_valid) begin
          value_d   = load_value;
          scratch_d = '0;
          bit_cnt_d = '0;
        end
      end
      SHIFT: begin
        scratch_d = (adjusted << 1) | SCR_W'(value_q[DATA_W-1]);
        value_d   = value_q << 1;
        bit_cnt_d = bit_cnt_q + 1'b1;
      end
      COMMIT: begin
        disp_d     = scratch_q[DISP_W-1:0];
        overflow_d = hi_nonzero;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock_100Mhz or posedge reset) begin
    if (reset) begin
      value_q    <= '0;
      scratch_q  <= '0;
      bit_cnt_q  <= '0;
      disp_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      value_q    <= value_d;
      scratch_q  <= scratch_d;
      bit_cnt_q  <= bit_cnt_d;
      disp_q     <= disp_d;
      overflow_q <= overflow_d;
    end
  end

  always_comb begin
    refresh_d = refresh_q + 1'b1;
    index_d   = index_q;
    if (refresh_q == REF_W'(REFRESH_DIV - 1)) begin
      refresh_d = '0;
      index_d   = (index_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : index_q + 1'b1;
    end
  end

  // The digit is blanked when it and every more significant digit are zero.
  always_comb begin
    upper_digits = disp_q >> {index_q, 2'b00};
    unique case (upper_digits[3:0])
      4'd0:    seg_hi = 7'b1111110;
      4'd1:    seg_hi = 7'b0110000;
      4'd2:    seg_hi = 7'b1101101;
      4'd3:    seg_hi = 7'b1111001;
      4'd4:    seg_hi = 7'b0110011;
      4'd5:    seg_hi = 7'b1011011;
      4'd6:    seg_hi = 7'b1011111;
      4'd7:    seg_hi = 7'b1110000;
      4'd8:    seg_hi = 7'b1111111;
      4'd9:    seg_hi = 7'b1111011;
      default: seg_hi = 7'b0000000;
    endcase
    if (overflow_q) seg_hi = 7'b0000001;
    else if ((BLANK_LZ != 0) && (index_q != '0) && (upper_digits == '0)) seg_hi = 7'b0000000;
    anode_hi          = '0;
    anode_hi[index_q] = 1'b1;
    anode_d = (ACTIVE_LOW != 0) ? ~anode_hi : anode_hi;
    led_d   = (ACTIVE_LOW != 0) ? ~seg_hi : seg_hi;
    dp_d    = (ACTIVE_LOW != 0) ? ~dp_mask[index_q] : dp_mask[index_q];
  end

  always_ff @(posedge clock_100Mhz or posedge reset) begin
    if (reset) begin
      refresh_q <= '0;
      index_q   <= '0;
      anode_q   <= ANODE_OFF;
      led_q     <= LED_OFF;
      dp_q      <= DP_OFF;
    end else begin
      refresh_q <= refresh_d;
      index_q   <= index_d;
      anode_q   <= anode_d;
      led_q     <= led_d;
      dp_q      <= dp_d;
    end
  end

  assign overflow       = overflow_q;
  assign Anode_Activate = anode_q;
  assign LED_out        = led_q;
  assign DP_out         = dp_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Bench for seven_seg_scan_ctrl: two instances (leading-zero blanking on and off) share stimulus
// and are compared against a decimal-arithmetic model of the expected display.
module tb_seven_seg_scan_ctrl;
  localparam int ND = 4;
  localparam int DW = 16;
  localparam int RD = 4;

  logic          clock_100Mhz = 1'b0;
  logic          reset = 1'b1;
  logic          load_valid = 1'b0;
  logic [DW-1:0] load_value = '0;
  logic [ND-1:0] dp_mask = '0;
  logic          ready_a, busy_a, ovf_a, dp_a;
  logic          ready_b, busy_b, ovf_b, dp_b;
  logic [ND-1:0] anode_a, anode_b;
  logic [6:0]    led_a, led_b;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int model_value = 0;

  seven_seg_scan_ctrl #(.NUM_DIGITS(ND), .DATA_W(DW), .REFRESH_DIV(RD), .ACTIVE_LOW(1), .BLANK_LZ(1)) dut_a (
    .clock_100Mhz(clock_100Mhz), .reset(reset), .load_valid(load_valid), .load_ready(ready_a),
    .load_value(load_value), .dp_mask(dp_mask), .busy(busy_a), .overflow(ovf_a),
    .Anode_Activate(anode_a), .LED_out(led_a), .DP_out(dp_a));

  seven_seg_scan_ctrl #(.NUM_DIGITS(ND), .DATA_W(DW), .REFRESH_DIV(RD), .ACTIVE_LOW(1), .BLANK_LZ(0)) dut_b (
    .clock_100Mhz(clock_100Mhz), .reset(reset), .load_valid(load_valid), .load_ready(ready_b),
    .load_value(load_value), .dp_mask(dp_mask), .busy(busy_b), .overflow(ovf_b),
    .Anode_Activate(anode_b), .LED_out(led_b), .DP_out(dp_b));

  always #5 clock_100Mhz = ~clock_100Mhz;

  // Clocks since reset release; the active digit follows from it directly.
  always @(posedge clock_100Mhz or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b0000001;  1: return 7'b1001111;  2: return 7'b0010010;
      3: return 7'b0000110;  4: return 7'b1001100;  5: return 7'b0100100;
      6: return 7'b0100000;  7: return 7'b0001111;  8: return 7'b0000000;
      default: return 7'b0000100;
    endcase
  endfunction

  function automatic logic [6:0] exp_led(input int value, input int digit, input bit blank_lz);
    int pw;
    pw = 1;
    for (int i = 0; i < digit; i++) pw = pw * 10;
    if (value > 9999) return 7'b1111110;
    if (blank_lz && digit > 0 && value < pw) return 7'h7F;
    return seg_of((value / pw) % 10);
  endfunction

  function automatic int exp_digit(input int c);
    return ((c - 1) / RD) % ND;
  endfunction

  function automatic logic [ND-1:0] exp_anode(input int d);
    logic [ND-1:0] one;
    one = 1;
    return ~(one << d);
  endfunction

  task automatic do_load(input int value, output int busy_cycles);
    @(negedge clock_100Mhz);
    load_value = DW'(value);
    load_valid = 1'b1;
    @(posedge clock_100Mhz);
    #1 load_valid = 1'b0;
    busy_cycles = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock_100Mhz);
      if (!busy_a) break;
      busy_cycles++;
    end
    model_value = value;
  endtask

  task automatic test_reset();
    int d;
    reset = 1'b1;
    dp_mask = '0;
    repeat (2) @(negedge clock_100Mhz);
    vectors += 5;
    if (anode_a !== 4'hF) begin miscompares++; $display("[TB] FAIL reset_anode: got %b want 1111", anode_a); end
    if (led_a !== 7'h7F) begin miscompares++; $display("[TB] FAIL reset_led: got %b want 1111111", led_a); end
    if (dp_a !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_dp: got %b want 1", dp_a); end
    if (busy_a !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy: got %b want 0", busy_a); end
    if (ovf_a !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_ovf: got %b want 0", ovf_a); end
    reset = 1'b0;
    model_value = 0;
    vectors += 2;
    if (ready_a !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_ready: got %b want 1", ready_a); end
    if (anode_a !== 4'hF) begin miscompares++; $display("[TB] FAIL release_anode: got %b want 1111", anode_a); end
    for (int k = 0; k < 20; k++) begin
      @(negedge clock_100Mhz);
      d = exp_digit(cyc);
      vectors += 3;
      if (anode_a !== exp_anode(d)) begin miscompares++; $display("[TB] FAIL scan_anode: cyc %0d got %b want %b", cyc, anode_a, exp_anode(d)); end
      if (led_a !== exp_led(0, d, 1)) begin miscompares++; $display("[TB] FAIL scan_led_a: digit %0d got %b want %b", d, led_a, exp_led(0, d, 1)); end
      if (led_b !== exp_led(0, d, 0)) begin miscompares++; $display("[TB] FAIL scan_led_b: digit %0d got %b want %b", d, led_b, exp_led(0, d, 0)); end
    end
  endtask

  task automatic test_load_1234();
    int bc, d;
    do_load(1234, bc);
    vectors += 3;
    if (bc !== 17) begin miscompares++; $display("[TB] FAIL 1234_busy_cycles: got %0d want 17", bc); end
    if (ready_a !== 1'b1) begin miscompares++; $display("[TB] FAIL 1234_ready: got %b want 1", ready_a); end
    if (ovf_a !== 1'b0) begin miscompares++; $display("[TB] FAIL 1234_ovf: got %b want 0", ovf_a); end
    for (int k = 0; k < 16; k++) begin
      @(negedge clock_100Mhz);
      d = exp_digit(cyc);
      vectors += 2;
      if (anode_a !== exp_anode(d)) begin miscompares++; $display("[TB] FAIL 1234_anode: got %b want %b", anode_a, exp_anode(d)); end
      if (led_a !== exp_led(model_value, d, 1)) begin miscompares++; $display("[TB] FAIL 1234_led: digit %0d got %b want %b", d, led_a, exp_led(model_value, d, 1)); end
    end
  endtask

  task automatic test_blanking();
    int bc, d;
    do_load(7, bc);
    vectors += 1;
    if (bc !== 17) begin miscompares++; $display("[TB] FAIL blank_busy_cycles: got %0d want 17", bc); end
    for (int k = 0; k < 16; k++) begin
      @(negedge clock_100Mhz);
      d = exp_digit(cyc);
      vectors += 2;
      if (led_a !== exp_led(7, d, 1)) begin miscompares++; $display("[TB] FAIL blank_lz1: digit %0d got %b want %b", d, led_a, exp_led(7, d, 1)); end
      if (led_b !== exp_led(7, d, 0)) begin miscompares++; $display("[TB] FAIL blank_lz0: digit %0d got %b want %b", d, led_b, exp_led(7, d, 0)); end
    end
  endtask

  task automatic test_overflow();
    int bc, d;
    int vals [2] = '{12345, 9999};
    for (int j = 0; j < 2; j++) begin
      do_load(vals[j], bc);
      vectors += 2;
      if (bc !== 17) begin miscompares++; $display("[TB] FAIL ovf_busy_cycles: got %0d want 17", bc); end
      if (ovf_a !== (vals[j] > 9999)) begin miscompares++; $display("[TB] FAIL ovf_flag: value %0d got %b want %b", vals[j], ovf_a, vals[j] > 9999); end
      for (int k = 0; k < 16; k++) begin
        @(negedge clock_100Mhz);
        d = exp_digit(cyc);
        vectors += 2;
        if (led_a !== exp_led(vals[j], d, 1)) begin miscompares++; $display("[TB] FAIL ovf_led_a: value %0d digit %0d got %b want %b", vals[j], d, led_a, exp_led(vals[j], d, 1)); end
        if (led_b !== exp_led(vals[j], d, 0)) begin miscompares++; $display("[TB] FAIL ovf_led_b: value %0d digit %0d got %b want %b", vals[j], d, led_b, exp_led(vals[j], d, 0)); end
      end
    end
  endtask

  task automatic test_ignore_during_shift();
    int d;
    dp_mask = 4'b0100;
    @(negedge clock_100Mhz);
    load_value = 16'd500;
    load_valid = 1'b1;
    @(posedge clock_100Mhz);
    #1 load_valid = 1'b0;
    repeat (5) @(negedge clock_100Mhz);
    load_value = 16'd42;
    load_valid = 1'b1;
    repeat (2) @(negedge clock_100Mhz);
    load_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock_100Mhz);
      if (!busy_a) break;
    end
    model_value = 500;
    vectors += 1;
    if (busy_a !== 1'b0) begin miscompares++; $display("[TB] FAIL ignore_timeout: busy got %b want 0", busy_a); end
    for (int k = 0; k < 16; k++) begin
      @(negedge clock_100Mhz);
      d = exp_digit(cyc);
      vectors += 2;
      if (led_a !== exp_led(500, d, 1)) begin miscompares++; $display("[TB] FAIL ignore_led: digit %0d got %b want %b", d, led_a, exp_led(500, d, 1)); end
      if (dp_a !== (d != 2)) begin miscompares++; $display("[TB] FAIL ignore_dp: digit %0d got %b want %b", d, dp_a, d != 2); end
    end
  endtask

  task automatic test_random();
    int bc, d, v;
    for (int j = 0; j < 10; j++) begin
      case (j)
        0: v = 0;
        1: v = 9999;
        2: v = 10000;
        3: v = 65535;
        default: v = int'($urandom_range(0, 65535));
      endcase
      dp_mask = ND'($urandom_range(0, 15));
      do_load(v, bc);
      vectors += 3;
      if (bc !== 17) begin miscompares++; $display("[TB] FAIL rand_busy_cycles: value %0d got %0d want 17", v, bc); end
      if (ovf_a !== (v > 9999)) begin miscompares++; $display("[TB] FAIL rand_ovf: value %0d got %b want %b", v, ovf_a, v > 9999); end
      if (ready_b !== 1'b1) begin miscompares++; $display("[TB] FAIL rand_ready: got %b want 1", ready_b); end
      for (int k = 0; k < 16; k++) begin
        @(negedge clock_100Mhz);
        d = exp_digit(cyc);
        vectors += 3;
        if (led_a !== exp_led(v, d, 1)) begin miscompares++; $display("[TB] FAIL rand_led_a: value %0d digit %0d got %b want %b", v, d, led_a, exp_led(v, d, 1)); end
        if (led_b !== exp_led(v, d, 0)) begin miscompares++; $display("[TB] FAIL rand_led_b: value %0d digit %0d got %b want %b", v, d, led_b, exp_led(v, d, 0)); end
        if (dp_a !== ~dp_mask[d]) begin miscompares++; $display("[TB] FAIL rand_dp: digit %0d got %b want %b", d, dp_a, ~dp_mask[d]); end
      end
    end
  endtask

  task automatic test_reset_mid_shift();
    int d;
    dp_mask = '0;
    @(negedge clock_100Mhz);
    load_value = 16'd4321;
    load_valid = 1'b1;
    @(posedge clock_100Mhz);
    #1 load_valid = 1'b0;
    repeat (6) @(negedge clock_100Mhz);
    reset = 1'b1;
    #1;
    vectors += 4;
    if (anode_a !== 4'hF) begin miscompares++; $display("[TB] FAIL midrst_anode: got %b want 1111", anode_a); end
    if (led_a !== 7'h7F) begin miscompares++; $display("[TB] FAIL midrst_led: got %b want 1111111", led_a); end
    if (busy_a !== 1'b0) begin miscompares++; $display("[TB] FAIL midrst_busy: got %b want 0", busy_a); end
    if (ovf_a !== 1'b0) begin miscompares++; $display("[TB] FAIL midrst_ovf: got %b want 0", ovf_a); end
    @(negedge clock_100Mhz);
    reset = 1'b0;
    model_value = 0;
    vectors += 1;
    if (ready_a !== 1'b1) begin miscompares++; $display("[TB] FAIL midrst_ready: got %b want 1", ready_a); end
    for (int k = 0; k < 16; k++) begin
      @(negedge clock_100Mhz);
      d = exp_digit(cyc);
      vectors += 3;
      if (anode_a !== exp_anode(d)) begin miscompares++; $display("[TB] FAIL midrst_scan_anode: got %b want %b", anode_a, exp_anode(d)); end
      if (led_a !== exp_led(0, d, 1)) begin miscompares++; $display("[TB] FAIL midrst_led_a: digit %0d got %b want %b", d, led_a, exp_led(0, d, 1)); end
      if (busy_a !== 1'b0) begin miscompares++; $display("[TB] FAIL midrst_idle: busy got %b want 0", busy_a); end
    end
  endtask

  initial begin
    test_reset();
    test_load_1234();
    test_blanking();
    test_overflow();
    test_ignore_during_shift();
    test_random();
    test_reset_mid_shift();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
